ps2tx_sched: RTL and testbench

Transmit scheduler in front of the PS/2 device-side serializer in the UART-to-PS/2 bridge. It buffers scancode bytes arriving from the UART path in a small FIFO and holds one priority response byte (e.g. 0xFA ACK, 0xAA BAT). It arbitrates between the two sources and hands one byte at a time to the serializer. It enforces an inter-byte gap, respects host inhibit, and retries bytes the host aborts mid-frame.

---
 rtl/ps2tx_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2tx_sched.sv
// ps2tx_sched - transmit scheduler in front of the PS/2 device-side serializer.
//
// Scancode bytes from the UART path are queued in a small circular FIFO. One
// priority response byte (ACK, BAT, ...) is held in a single register. The
// block arbitrates between the two sources, with the response winning, and
// hands one byte at a time to the serializer. It also enforces an idle gap
// after every completed frame and re-sends any byte the host aborts.
//
// Parameters
//   FIFO_AW      log2 of scancode FIFO depth
//   GAP_CYCLES   idle cycles after each completed frame (0 = no gap)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   kbd_data      scancode byte to queue
//   kbd_strobe    one-cycle push of kbd_data
//   rsp_data      priority response byte
//   rsp_strobe    one-cycle load of rsp_data (latest wins)
//   flush         one-cycle FIFO clear
//   host_inhibit  host holding PS/2 clock low (sampled only while idle)
//   tx_data       byte presented to the serializer
//   tx_start      one-cycle frame start pulse
//   tx_busy       serializer frame in progress
//   tx_abort      serializer aborted the current frame
//   fifo_level    bytes currently queued
//   overflow      one-cycle pulse when a scancode is dropped on a full FIFO
module ps2tx_sched #(
  parameter int          FIFO_AW    = 3,
  parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         kbd_data,
  input  logic               kbd_strobe,
  input  logic [7:0]         rsp_data,
  input  logic               rsp_strobe,
  input  logic               flush,
  input  logic               host_inhibit,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic               tx_abort,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int                DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_LEVEL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_SENDING,
    S_GAP
  } state_t;

  // Scancode FIFO
  logic [7:0]          fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_reg;
  logic [FIFO_AW-1:0]  rd_ptr_reg;
  logic [FIFO_AW:0]    level_reg;
  logic                overflow_reg;

  // Response register
  logic [7:0]          rsp_byte_reg;
  logic                rsp_pending_reg;

  // Scheduler
  state_t              state_reg;
  state_t              state_next;
  logic [7:0]          tx_data_reg;
  logic                src_rsp_reg;    // in-flight byte came from the response register
  logic                aborted_reg;    // serializer reported an abort during this frame
  logic                reloaded_reg;   // a new response arrived while the old one was in flight
  logic                flushed_reg;    // FIFO was flushed while its head was in flight
  logic [15:0]         gap_cnt_reg;

  logic                do_latch;
  logic                do_consume;
  logic                in_flight;
  logic                fifo_full;
  logic                push_ok;
  logic                pop;

  assign in_flight = (state_reg == S_ISSUE) || (state_reg == S_WAIT_BUSY) ||
                     (state_reg == S_SENDING);
  assign fifo_full = (level_reg == FULL_LEVEL);
  // Fullness is judged on the level before any same-cycle pop; a flush empties
  // the FIFO first, so a push alongside a flush always lands.
  assign push_ok   = kbd_strobe && (flush || !fifo_full);
  // A flush (earlier or in this cycle) already removed the in-flight head.
  assign pop       = do_consume && !src_rsp_reg && !flushed_reg && !flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    do_latch   = 1'b0;
    do_consume = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!host_inhibit && (rsp_pending_reg || (level_reg != '0))) begin
          do_latch   = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Busy wins; an abort seen together with busy is remembered via aborted_reg.
        if (tx_busy) begin
          state_next = S_SENDING;
        end else if (tx_abort) begin
          state_next = S_IDLE;
        end
      end
      S_SENDING: begin
        if (!tx_busy) begin
          if (aborted_reg || tx_abort) begin
            state_next = S_IDLE;
          end else begin
            do_consume = 1'b1;
            state_next = (GAP_CYCLES == 16'd0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 16'd0) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset; contents are only meaningful below level_reg).
  // Read asynchronously so the head is available in the arbitration cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[flush ? '0 : wr_ptr_reg] <= kbd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= kbd_strobe && !flush && fifo_full;
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= FIFO_AW'(push_ok);
        level_reg  <= (FIFO_AW+1)'(push_ok);
      end else begin
        if (push_ok) begin
          wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
        end
        case ({push_ok, pop})
          2'b10:   level_reg <= level_reg + (FIFO_AW+1)'(1);
          2'b01:   level_reg <= level_reg - (FIFO_AW+1)'(1);
          default: level_reg <= level_reg;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_byte_reg    <= 8'h00;
      rsp_pending_reg <= 1'b0;
    end else begin
      if (rsp_strobe) begin
        rsp_byte_reg    <= rsp_data;
        rsp_pending_reg <= 1'b1;
      end else if (do_consume && src_rsp_reg && !reloaded_reg) begin
        rsp_pending_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler state, latched byte and per-frame flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      tx_data_reg  <= 8'h00;
      src_rsp_reg  <= 1'b0;
      aborted_reg  <= 1'b0;
      reloaded_reg <= 1'b0;
      flushed_reg  <= 1'b0;
      gap_cnt_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;

      if (do_latch) begin
        tx_data_reg  <= rsp_pending_reg ? rsp_byte_reg : fifo_mem[rd_ptr_reg];
        src_rsp_reg  <= rsp_pending_reg;
        // A strobe/flush in the pick cycle already replaced the picked item.
        reloaded_reg <= rsp_pending_reg && rsp_strobe;
        flushed_reg  <= !rsp_pending_reg && flush;
      end else if (in_flight) begin
        if (src_rsp_reg && rsp_strobe) begin
          reloaded_reg <= 1'b1;
        end
        if (!src_rsp_reg && flush) begin
          flushed_reg <= 1'b1;
        end
      end

      // Only meaningful while the frame is on the wire; cleared on every exit.
      aborted_reg <= (state_next == S_SENDING) && (aborted_reg || tx_abort);

      if (do_consume) begin
        gap_cnt_reg <= GAP_CYCLES - 16'd1;
      end else if ((state_reg == S_GAP) && (gap_cnt_reg != 16'd0)) begin
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      end
    end
  end

  assign tx_start   = (state_reg == S_ISSUE);
  assign tx_data    = tx_data_reg;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2tx_sched.sv
// Testbench for ps2tx_sched: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a queue-based reference model of the
// scheduler's rules plus a simple serializer model that drives tx_busy/tx_abort.
module tb_ps2tx_sched;

  localparam int G = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_strobe = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_strobe = 1'b0;
  logic       flush = 1'b0;
  logic       host_inhibit = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       tx_abort = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;

  ps2tx_sched #(.FIFO_AW(3), .GAP_CYCLES(16'(G))) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .kbd_data     (kbd_data),
    .kbd_strobe   (kbd_strobe),
    .rsp_data     (rsp_data),
    .rsp_strobe   (rsp_strobe),
    .flush        (flush),
    .host_inhibit (host_inhibit),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_abort     (tx_abort),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: queued scancodes, pending response, and the frame in flight
  logic [7:0] kq[$];
  bit         rp;
  logic [7:0] rb;
  int         t;
  int         free_at;      // first cycle in which the scheduler may pick again
  bit         fr_active, fr_rsp, fr_reload, fr_flushed, fr_aborted, fr_seen_busy;
  logic [7:0] fr_byte;
  bit         exp_start, exp_ovf;
  logic [7:0] exp_data;

  // Serializer model
  int ser_rem;        // busy cycles remaining
  int ser_abort_at;   // abort pulse when ser_rem equals this (0 = none)
  int abort_mode;     // 0 none, 1 abort next frame, 2 random

  int         starts_seen;
  bit         saw_55;
  logic [7:0] sent[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    rp = 0; rb = 8'h00;
    free_at = t;
    fr_active = 0; fr_rsp = 0; fr_reload = 0; fr_flushed = 0;
    fr_aborted = 0; fr_seen_busy = 0; fr_byte = 8'h00;
    exp_start = 0; exp_ovf = 0; exp_data = 8'h00;
    ser_rem = 0; ser_abort_at = 0;
    tx_busy = 1'b0; tx_abort = 1'b0;
  endtask

  // One clock cycle: drive serializer, check outputs, advance the model, clock.
  task automatic cycle();
    bit arb, arb_rsp, comp, full_pre, nxt_start, nxt_ovf;
    logic [7:0] arb_byte;
    int len;
    tx_busy  = (ser_rem > 0);
    tx_abort = (ser_rem > 0) && (ser_rem == ser_abort_at);
    arb = !fr_active && (t >= free_at) && !host_inhibit && (rp || kq.size() != 0);
    // Keep strobe/flush out of the pick cycle itself
    if (arb) begin
      rsp_strobe = 1'b0;
      flush = 1'b0;
    end
    #1;
    chk("tx_start", tx_start, exp_start);
    if (exp_start) chk("tx_data", tx_data, exp_data);
    else if (fr_active) chk("tx_data_hold", tx_data, fr_byte);
    chk("fifo_level", fifo_level, kq.size());
    chk("overflow", overflow, exp_ovf);
    if (tx_start === 1'b1) begin
      starts_seen++;
      sent.push_back(tx_data);
      if (tx_data == 8'h55) saw_55 = 1;
    end

    arb_rsp  = rp;
    arb_byte = rp ? rb : ((kq.size() != 0) ? kq[0] : 8'h00);
    full_pre = (kq.size() == 8);
    comp     = fr_active && fr_seen_busy && !tx_busy;
    if (fr_active) begin
      if (tx_busy) fr_seen_busy = 1;
      if (tx_abort) fr_aborted = 1;
      if (rsp_strobe && fr_rsp) fr_reload = 1;
      if (flush && !fr_rsp) fr_flushed = 1;
    end
    if (comp) begin
      if (!fr_aborted) begin
        if (fr_rsp) begin
          if (!fr_reload) rp = 0;
        end else if (!fr_flushed) begin
          void'(kq.pop_front());
        end
        free_at = t + 1 + G;
      end else begin
        free_at = t + 1;
      end
      fr_active = 0;
    end
    if (flush) kq.delete();
    nxt_ovf = 0;
    if (kbd_strobe) begin
      if (flush || !full_pre) kq.push_back(kbd_data);
      else nxt_ovf = 1;
    end
    if (rsp_strobe) begin
      rb = rsp_data;
      rp = 1;
    end
    nxt_start = 0;
    if (arb) begin
      fr_active = 1; fr_rsp = arb_rsp; fr_byte = arb_byte;
      fr_reload = 0; fr_flushed = 0; fr_aborted = 0; fr_seen_busy = 0;
      nxt_start = 1; exp_data = arb_byte;
    end

    if (tx_start === 1'b1) begin
      if (abort_mode == 1) begin
        len = $urandom_range(3, 8);
        ser_abort_at = $urandom_range(1, len - 1);
        abort_mode = 0;
      end else begin
        len = $urandom_range(2, 8);
        ser_abort_at = 0;
        if (abort_mode == 2 && $urandom_range(0, 3) == 0)
          ser_abort_at = $urandom_range(1, len - 1);
      end
      ser_rem = len;
    end else if (ser_rem > 0) begin
      ser_rem--;
    end

    @(posedge clk);
    #1;
    exp_start = nxt_start;
    exp_ovf = nxt_ovf;
    t++;
    kbd_strobe = 1'b0;
    rsp_strobe = 1'b0;
    flush = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    kbd_data = b;
    kbd_strobe = 1'b1;
    cycle();
  endtask

  task automatic wait_sending(input string tag);
    int k;
    for (k = 0; k < 200 && !(fr_active && fr_seen_busy); k++) cycle();
    chk(tag, 32'(fr_active && fr_seen_busy), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 5000 && !(!fr_active && kq.size() == 0 && !rp && t >= free_at); k++)
      cycle();
    chk(tag, 32'(!fr_active && kq.size() == 0 && !rp && t >= free_at), 32'd1);
  endtask

  initial begin
    int s0;
    t = 0;
    abort_mode = 0;
    starts_seen = 0;
    saw_55 = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    model_reset();

    // Three scancodes in order, gap enforced between frames
    s0 = starts_seen;
    sent.delete();
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_drain("p1_drain");
    chk("p1_starts", starts_seen - s0, 3);
    chk("p1_order0", sent[0], 8'h1C);
    chk("p1_order1", sent[1], 8'hF0);
    chk("p1_order2", sent[2], 8'h1C);
    chk("p1_level", fifo_level, 0);

    // Fill to 8 while inhibited, 9th byte dropped
    host_inhibit = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    push(8'h55);
    chk("p2_overflow", overflow, 1);
    cycle();
    chk("p2_level", fifo_level, 8);
    host_inhibit = 1'b0;
    wait_drain("p2_drain");
    chk("p2_no_55", 32'(saw_55), 0);

    // Response pre-empts a queued scancode
    sent.delete();
    push(8'h2B); push(8'h1C);
    wait_sending("p3_sending");
    rsp_data = 8'hFA;
    rsp_strobe = 1'b1;
    cycle();
    wait_drain("p3_drain");
    chk("p3_count", sent.size(), 3);
    chk("p3_first", sent[0], 8'h2B);
    chk("p3_rsp", sent[1], 8'hFA);
    chk("p3_kbd", sent[2], 8'h1C);

    // Aborted frame stays queued; inhibit blocks the retry until released
    abort_mode = 1;
    push(8'h2A);
    wait_sending("p4_sending");
    host_inhibit = 1'b1;
    for (int k = 0; k < 100 && fr_active; k++) cycle();
    s0 = starts_seen;
    repeat (30) cycle();
    chk("p4_level", fifo_level, 1);
    chk("p4_blocked", starts_seen - s0, 0);
    sent.delete();
    host_inhibit = 1'b0;
    wait_drain("p4_drain");
    chk("p4_resend", sent[0], 8'h2A);
    chk("p4_count", sent.size(), 1);

    // Flush while a scancode is in flight with three more queued
    host_inhibit = 1'b1;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    host_inhibit = 1'b0;
    wait_sending("p5_sending");
    flush = 1'b1;
    cycle();
    chk("p5_level", fifo_level, 0);
    s0 = starts_seen;
    wait_drain("p5_drain");
    chk("p5_no_starts", starts_seen - s0, 0);

    // Randomized traffic
    abort_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) host_inhibit = ~host_inhibit;
      if ($urandom_range(0, 5) == 0) begin
        kbd_data = 8'($urandom);
        kbd_strobe = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        rsp_data = 8'($urandom);
        rsp_strobe = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) flush = 1'b1;
      cycle();
    end
    abort_mode = 0;
    host_inhibit = 1'b0;
    wait_drain("rand_drain");

    // Asynchronous reset in the middle of a frame
    host_inhibit = 1'b1;
    push(8'h41); push(8'h42); push(8'h43);
    host_inhibit = 1'b0;
    wait_sending("p6_sending");
    #3;
    reset_n = 1'b0;
    #1;
    chk("p6_tx_start", tx_start, 0);
    chk("p6_tx_data", tx_data, 0);
    chk("p6_level", fifo_level, 0);
    chk("p6_overflow", overflow, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    s0 = starts_seen;
    repeat (40) cycle();
    chk("p6_no_starts", starts_seen - s0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
